// File: rtl/or1200_enc_pad_sequencer_pkg.sv
// Shared types for the encryption pad sequencer: FSM state encoding and counter width.
package or1200_enc_pad_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_t;

    localparam int REMAIN_W = 8;

endpackage

// File: rtl/or1200_enc_pad_fifo.sv
// Small pad FIFO with flush; head entry is read combinationally and forced to zero when empty.
module or1200_enc_pad_fifo #(
    parameter int DW    = 129,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [DW-1:0]              din,
    output logic [DW-1:0]              dout,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg < CW'(DEPTH)) || do_pop);

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (do_push && (wr_ptr_reg == AW'(gi))) mem[gi] <= din;
            end
        end
    endgenerate

    assign dout  = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
    assign count = count_reg;

endmodule

// File: rtl/or1200_enc_pad_sequencer.sv
// Sequences the shared AES core to build bursts of CTR/OFB pads per seed,
// buffering results in a FIFO and tagging the first pad of each seed.
module or1200_enc_pad_sequencer
    import or1200_enc_pad_sequencer_pkg::*;
#(
    parameter int DW    = 128,
    parameter int DEPTH = 4,
    parameter int NPADS = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode_ofb,
    input  logic          seed_valid,
    input  logic [DW-1:0] seed,
    output logic          seed_ready,
    input  logic          abort,
    output logic          aes_start,
    output logic [DW-1:0] aes_din,
    input  logic          aes_done,
    input  logic [DW-1:0] aes_dout,
    output logic          pad_valid,
    output logic [DW-1:0] pad,
    output logic          pad_first,
    input  logic          pad_pop,
    output logic          busy
);
    localparam int CW = $clog2(DEPTH) + 1;

    seq_state_t            state_reg, state_next;
    logic [DW-1:0]         work_reg, work_next;
    logic [REMAIN_W-1:0]   remaining_reg, remaining_next;
    logic                  first_reg, first_next;
    logic                  mode_reg, mode_next;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic [CW-1:0]         fifo_count;
    logic [DW:0]           fifo_dout;
    logic                  space;

    assign space    = fifo_count < CW'(DEPTH);
    assign pad_valid = fifo_count != '0;
    assign fifo_pop = pad_valid && pad_pop;
    assign pad_first = fifo_dout[DW];
    assign pad       = fifo_dout[DW-1:0];
    assign busy      = state_reg != ST_IDLE;
    assign aes_din   = aes_start ? work_reg : '0;

    or1200_enc_pad_fifo #(
        .DW    (DW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (abort),
        .din   ({first_reg, aes_dout}),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    always_comb begin
        state_next     = state_reg;
        work_next      = work_reg;
        remaining_next = remaining_reg;
        first_next     = first_reg;
        mode_next      = mode_reg;
        seed_ready     = 1'b0;
        aes_start      = 1'b0;
        fifo_push      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                seed_ready = !abort;
                if (seed_valid && !abort) begin
                    work_next      = seed;
                    mode_next      = mode_ofb;
                    remaining_next = REMAIN_W'(NPADS);
                    first_next     = 1'b1;
                    state_next     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Issue only with a free slot, so the single outstanding result always fits.
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (space) begin
                    aes_start  = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_next = aes_done ? ST_IDLE : ST_DRAIN;
                end else if (aes_done) begin
                    fifo_push      = 1'b1;
                    first_next     = 1'b0;
                    work_next      = mode_reg ? aes_dout : work_reg + DW'(1);
                    remaining_next = remaining_reg - REMAIN_W'(1);
                    state_next     = (remaining_reg == REMAIN_W'(1)) ? ST_IDLE : ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (aes_done || abort) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (abort) first_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            work_reg      <= '0;
            remaining_reg <= '0;
            first_reg     <= 1'b0;
            mode_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            work_reg      <= work_next;
            remaining_reg <= remaining_next;
            first_reg     <= first_next;
            mode_reg      <= mode_next;
        end
    end

endmodule

// File: tb/tb_or1200_enc_pad_sequencer.sv
// Directed bench for the pad sequencer with a fixed-latency AES model.
module tb_or1200_enc_pad_sequencer;
    localparam int DW    = 128;
    localparam int DEPTH = 4;
    localparam int NPADS = 2;
    localparam logic [DW-1:0] K = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mode_ofb = 1'b0;
    logic          seed_valid = 1'b0;
    logic [DW-1:0] seed = '0;
    logic          abort = 1'b0;
    logic          aes_done = 1'b0;
    logic [DW-1:0] aes_dout = '0;
    logic          pad_pop = 1'b0;
    logic          seed_ready;
    logic          aes_start;
    logic [DW-1:0] aes_din;
    logic          pad_valid;
    logic [DW-1:0] pad;
    logic          pad_first;
    logic          busy;

    int errors = 0;
    int checks = 0;

    or1200_enc_pad_sequencer #(.DW(DW), .DEPTH(DEPTH), .NPADS(NPADS)) dut (
        .clk(clk), .rst(rst), .mode_ofb(mode_ofb), .seed_valid(seed_valid), .seed(seed),
        .seed_ready(seed_ready), .abort(abort), .aes_start(aes_start), .aes_din(aes_din),
        .aes_done(aes_done), .aes_dout(aes_dout), .pad_valid(pad_valid), .pad(pad),
        .pad_first(pad_first), .pad_pop(pad_pop), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] f(input logic [DW-1:0] x);
        return {x[DW-2:0], x[DW-1]} ^ K;
    endfunction

    // AES model: result three cycles after the start cycle; keeps running through rst.
    logic          mdl_busy = 1'b0;
    int            mdl_cnt = 0;
    logic [DW-1:0] mdl_din = '0;
    always @(posedge clk) begin
        aes_done <= 1'b0;
        if (aes_start === 1'b1) begin
            mdl_busy <= 1'b1;
            mdl_cnt  <= 1;
            mdl_din  <= aes_din;
        end else if (mdl_busy) begin
            if (mdl_cnt == 0) begin
                aes_done <= 1'b1;
                aes_dout <= f(mdl_din);
                mdl_busy <= 1'b0;
            end else begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end
    end

    logic [DW-1:0] din_log[$];
    int start_count = 0;
    always @(posedge clk) begin
        if (aes_start === 1'b1) begin
            din_log.push_back(aes_din);
            start_count <= start_count + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_seed(input logic [DW-1:0] s, input logic ofb, output bit ok);
        ok = 1'b0;
        seed_valid = 1'b1;
        seed = s;
        mode_ofb = ofb;
        for (int i = 0; i < 100; i++) begin
            if (seed_ready === 1'b1) begin
                step(1);
                ok = 1'b1;
                break;
            end
            step(1);
        end
        seed_valid = 1'b0;
        $display("seed %h mode_ofb=%0b accepted=%0b", s, ofb, ok);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic pop_one;
        $display("pop pad=%h first=%0b", pad, pad_first);
        pad_pop = 1'b1;
        step(1);
        pad_pop = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(2);
        checks++; if (aes_start !== 1'b0) begin errors++; $display("FAIL rst_aes_start got=%b exp=0", aes_start); end
        checks++; if (aes_din !== '0) begin errors++; $display("FAIL rst_aes_din got=%h exp=0", aes_din); end
        checks++; if (pad_valid !== 1'b0) begin errors++; $display("FAIL rst_pad_valid got=%b exp=0", pad_valid); end
        checks++; if (pad !== '0) begin errors++; $display("FAIL rst_pad got=%h exp=0", pad); end
        checks++; if (pad_first !== 1'b0) begin errors++; $display("FAIL rst_pad_first got=%b exp=0", pad_first); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        rst = 1'b0;
        #1;
        checks++; if (seed_ready !== 1'b1) begin errors++; $display("FAIL rst_seed_ready got=%b exp=1", seed_ready); end
        step(1);
    endtask

    task automatic test_ctr_burst;
        logic [DW-1:0] s = DW'(255);
        int base = din_log.size();
        int sc0 = start_count;
        bit ok;
        send_seed(s, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ctr_accept got=timeout exp=accept"); end
        checks++; if (aes_start !== 1'b1 || aes_din !== s) begin errors++; $display("FAIL ctr_first_start got=%b/%h exp=1/%h", aes_start, aes_din, s); end
        step(1);
        checks++; if (aes_start !== 1'b0 || aes_din !== '0) begin errors++; $display("FAIL ctr_start_one_cycle got=%b/%h exp=0/0", aes_start, aes_din); end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ctr_idle got=timeout exp=idle"); end
        checks++; if (start_count - sc0 != 2) begin errors++; $display("FAIL ctr_starts got=%0d exp=2", start_count - sc0); end
        checks++; if (din_log[base + 1] !== s + DW'(1)) begin errors++; $display("FAIL ctr_din2 got=%h exp=%h", din_log[base + 1], s + DW'(1)); end
        checks++; if (pad_valid !== 1'b1 || pad !== f(s) || pad_first !== 1'b1) begin errors++; $display("FAIL ctr_pad1 got=%b/%h/%b exp=1/%h/1", pad_valid, pad, pad_first, f(s)); end
        pop_one();
        checks++; if (pad_valid !== 1'b1 || pad !== f(s + DW'(1)) || pad_first !== 1'b0) begin errors++; $display("FAIL ctr_pad2 got=%b/%h/%b exp=1/%h/0", pad_valid, pad, pad_first, f(s + DW'(1))); end
        pop_one();
        checks++; if (pad_valid !== 1'b0) begin errors++; $display("FAIL ctr_empty got=%b exp=0", pad_valid); end
    endtask

    task automatic test_ofb_chain;
        logic [DW-1:0] s = 128'hDEADBEEF_00001111_22223333_44445555;
        int base = din_log.size();
        bit ok;
        send_seed(s, 1'b1, ok);
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL ofb_idle got=timeout exp=idle"); end
        checks++; if (din_log[base + 1] !== f(s)) begin errors++; $display("FAIL ofb_din2 got=%h exp=%h", din_log[base + 1], f(s)); end
        checks++; if (pad !== f(s) || pad_first !== 1'b1) begin errors++; $display("FAIL ofb_pad1 got=%h/%b exp=%h/1", pad, pad_first, f(s)); end
        pop_one();
        checks++; if (pad !== f(f(s)) || pad_first !== 1'b0) begin errors++; $display("FAIL ofb_pad2 got=%h/%b exp=%h/0", pad, pad_first, f(f(s))); end
        pop_one();
        checks++; if (pad_valid !== 1'b0) begin errors++; $display("FAIL ofb_empty got=%b exp=0", pad_valid); end
    endtask

    // Fill the FIFO with two bursts, stall a third, release one slot, then abort mid-WAIT.
    task automatic test_back_to_back;
        logic [DW-1:0] a = 128'h100;
        logic [DW-1:0] b = 128'h200;
        logic [DW-1:0] c = 128'h300;
        int sc0 = start_count;
        bit ok;
        bit seen;
        send_seed(a, 1'b0, ok);
        wait_idle(ok);
        checks++; if (seed_ready !== 1'b1 || pad_valid !== 1'b1) begin errors++; $display("FAIL b2b_ready_with_pads got=%b/%b exp=1/1", seed_ready, pad_valid); end
        send_seed(b, 1'b0, ok);
        wait_idle(ok);
        send_seed(c, 1'b0, ok);
        step(6);
        checks++; if (start_count - sc0 != 4) begin errors++; $display("FAIL bp_starts got=%0d exp=4", start_count - sc0); end
        checks++; if (aes_start !== 1'b0 || busy !== 1'b1 || seed_ready !== 1'b0) begin errors++; $display("FAIL bp_stall got=%b/%b/%b exp=0/1/0", aes_start, busy, seed_ready); end
        checks++; if (pad !== f(a) || pad_first !== 1'b1) begin errors++; $display("FAIL bp_head got=%h/%b exp=%h/1", pad, pad_first, f(a)); end
        pop_one();
        checks++; if (aes_start !== 1'b1 || aes_din !== c) begin errors++; $display("FAIL bp_release got=%b/%h exp=1/%h", aes_start, aes_din, c); end
        checks++; if (pad !== f(a + DW'(1)) || pad_first !== 1'b0) begin errors++; $display("FAIL bp_head2 got=%h/%b exp=%h/0", pad, pad_first, f(a + DW'(1))); end
        step(1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        #1;
        checks++; if (pad_valid !== 1'b0 || busy !== 1'b1 || seed_ready !== 1'b0) begin errors++; $display("FAIL abort_drain got=%b/%b/%b exp=0/1/0", pad_valid, busy, seed_ready); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (aes_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step(1);
        end
        checks++; if (!seen) begin errors++; $display("FAIL abort_late_done got=timeout exp=done"); end
        step(1);
        checks++; if (seed_ready !== 1'b1 || pad_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_recover got=%b/%b/%b exp=1/0/0", seed_ready, pad_valid, busy); end
    endtask

    task automatic test_fifo_edges;
        logic [DW-1:0] d = 128'h1234;
        bit ok;
        bit seen;
        send_seed(d, 1'b0, ok);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (pad_valid === 1'b1) begin seen = 1'b1; break; end
            step(1);
        end
        checks++; if (!seen || pad !== f(d)) begin errors++; $display("FAIL edge_first_pad got=%b/%h exp=1/%h", seen, pad, f(d)); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (aes_done === 1'b1) begin seen = 1'b1; break; end
            step(1);
        end
        pop_one();
        checks++; if (!seen || pad_valid !== 1'b1 || pad !== f(d + DW'(1)) || pad_first !== 1'b0) begin errors++; $display("FAIL edge_push_pop got=%b/%b/%h/%b exp=1/1/%h/0", seen, pad_valid, pad, pad_first, f(d + DW'(1))); end
        pop_one();
        checks++; if (pad_valid !== 1'b0) begin errors++; $display("FAIL edge_to_empty got=%b exp=0", pad_valid); end
        pad_pop = 1'b1;
        step(2);
        pad_pop = 1'b0;
        checks++; if (pad_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL edge_underflow got=%b/%b exp=0/0", pad_valid, busy); end
    endtask

    task automatic test_ctr_wrap;
        logic [DW-1:0] ones = '1;
        int base = din_log.size();
        bit ok;
        send_seed(ones, 1'b0, ok);
        wait_idle(ok);
        checks++; if (din_log[base + 1] !== '0) begin errors++; $display("FAIL wrap_din2 got=%h exp=0", din_log[base + 1]); end
        checks++; if (pad_valid !== 1'b1 || pad !== f(ones)) begin errors++; $display("FAIL wrap_pad got=%b/%h exp=1/%h", pad_valid, pad, f(ones)); end
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        checks++; if (pad_valid !== 1'b0 || pad !== '0) begin errors++; $display("FAIL idle_abort_flush got=%b/%h exp=0/0", pad_valid, pad); end
    endtask

    task automatic test_rst_mid_burst;
        logic [DW-1:0] e = 128'hABCD;
        bit ok;
        bit seen;
        send_seed(e, 1'b0, ok);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (aes_done === 1'b1) begin seen = 1'b1; break; end
            step(1);
        end
        step(1);
        checks++; if (!seen) begin errors++; $display("FAIL rstmid_done got=timeout exp=done"); end
        checks++; if (aes_start !== 1'b0 || aes_din !== '0 || busy !== 1'b0 || seed_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ctrl got=%b/%h/%b/%b exp=0/0/0/1", aes_start, aes_din, busy, seed_ready); end
        checks++; if (pad_valid !== 1'b0 || pad !== '0 || pad_first !== 1'b0) begin errors++; $display("FAIL rstmid_fifo got=%b/%h/%b exp=0/0/0", pad_valid, pad, pad_first); end
    endtask

    initial begin
        test_reset();
        test_ctr_burst();
        test_ofb_chain();
        test_back_to_back();
        test_fifo_edges();
        test_ctr_wrap();
        test_rst_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
